// File: rtl/sr_ff_pkg.sv
// Shared types for the SR flip-flop driver: FSM states and the {s,r} excitation
// codes, ordered to match the flop's own {s,r} case decode.
package sr_ff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2
  } state_e;

  localparam logic [1:0] EXC_HOLD    = 2'b00;
  localparam logic [1:0] EXC_RST     = 2'b01;
  localparam logic [1:0] EXC_SET     = 2'b10;
  localparam logic [1:0] EXC_ILLEGAL = 2'b11;

  function automatic logic exc_legal(input logic [1:0] exc);
    return exc != EXC_ILLEGAL;
  endfunction

endpackage

// File: rtl/sr_ff_driver_if.sv
// Request/excitation/readback bundle between sequencing logic (master) and the
// SR flop driver (slave); q_fb is the flop's Q routed back through the master side.
interface sr_ff_driver_if #(
  parameter int CNT_W = 8
);
  logic             req_valid;
  logic             req_bit;
  logic             req_ready;
  logic             s;
  logic             r;
  logic             q_fb;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] mismatch_cnt;

  modport master (
    output req_valid, req_bit, q_fb,
    input  req_ready, s, r, done, err, mismatch_cnt
  );

  modport slave (
    input  req_valid, req_bit, q_fb,
    output req_ready, s, r, done, err, mismatch_cnt
  );
endinterface

// File: rtl/sr_ff_driver_excite_enc.sv
// Maps (current Q, wanted Q) to the {s,r} excitation; the output is clamped so the
// forbidden s=r=1 code can never leave this block.
module sr_excite_enc
  import sr_ff_pkg::*;
(
  input  logic       q_now_i,
  input  logic       q_target_i,
  output logic [1:0] sr_o
);

  logic [1:0] code;

  // NOTE: every signal written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    code = EXC_HOLD;
    if (q_now_i != q_target_i) begin
      code = q_target_i ? EXC_SET : EXC_RST;
    end
    sr_o = exc_legal(code) ? code : EXC_HOLD;
  end

endmodule

// File: rtl/sr_ff_driver.sv
// SR flop driver: accepts target bits, pulses s/r for one cycle, verifies Q and
// reports done/err. Define SR_FF_DRIVER_RETRY_EN to re-drive up to MAX_RETRY times.
module sr_ff_driver
  import sr_ff_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MAX_RETRY = 2
) (
  input  logic            clk,
  input  logic            reset,
  sr_ff_driver_if.slave   bus
);

`ifdef SR_FF_DRIVER_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif
  localparam int RETRY_LIM = RETRY_EN ? MAX_RETRY : 0;
  localparam int RTRY_W    = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;

  state_e             state_q;
  logic               tgt_q;
  logic               s_q;
  logic               r_q;
  logic               done_q;
  logic               err_q;
  logic [CNT_W-1:0]   mismatch_cnt_q;
  logic [RTRY_W-1:0]  retry_q;

  logic               exc_tgt;
  logic [1:0]         exc_d;

  // In IDLE the excitation comes from the incoming bit; on a retry from the latched one.
  assign exc_tgt = (state_q == ST_IDLE) ? bus.req_bit : tgt_q;

  sr_excite_enc u_enc (
    .q_now_i    (bus.q_fb),
    .q_target_i (exc_tgt),
    .sr_o       (exc_d)
  );

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      tgt_q          <= 1'b0;
      s_q            <= 1'b0;
      r_q            <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      mismatch_cnt_q <= '0;
      retry_q        <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.req_valid) begin
            tgt_q      <= bus.req_bit;
            {s_q, r_q} <= exc_d;
            retry_q    <= '0;
            state_q    <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          {s_q, r_q} <= EXC_HOLD;
          state_q    <= ST_CHECK;
        end
        ST_CHECK: begin
          if (bus.q_fb == tgt_q) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            if (mismatch_cnt_q != '1) begin
              mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
            end
            if (int'(retry_q) < RETRY_LIM) begin
              retry_q    <= retry_q + 1'b1;
              {s_q, r_q} <= exc_d;
              state_q    <= ST_DRIVE;
            end else begin
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = (state_q == ST_IDLE);
  assign bus.s            = s_q;
  assign bus.r            = r_q;
  assign bus.done         = done_q;
  assign bus.err          = err_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;

endmodule

// File: tb/tb_sr_ff_driver.sv
// Directed + random bench for sr_ff_driver with an SR flop model (optionally stuck)
// and a scoreboard of expected done/err/latency per accepted request.
module tb_sr_ff_driver;
  import sr_ff_pkg::*;

`ifdef SR_FF_DRIVER_RETRY_EN
  localparam int FAILS_PER_REQ = 3;
  localparam int LAT_STUCK     = 6;
  localparam int LAT_FREED     = 4;
  localparam logic ERR_FREED   = 1'b0;
  localparam int SETS_FREED    = 2;
`else
  localparam int FAILS_PER_REQ = 1;
  localparam int LAT_STUCK     = 2;
  localparam int LAT_FREED     = 2;
  localparam logic ERR_FREED   = 1'b1;
  localparam int SETS_FREED    = 1;
`endif

  typedef struct {
    logic err;
    int   lat;
    int   acc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic q_model = 1'b1;
  logic stuck_en = 1'b0;
  logic stuck_val = 1'b0;
  bit   mon_en = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   fail_cnt = 0;
  int   done_cnt = 0;
  int   acc_cnt = 0;
  int   set_cycles = 0;
  exp_t sb_q[$];

  sr_ff_driver_if #(.CNT_W(8)) bus ();

  sr_ff_driver #(.CNT_W(8), .MAX_RETRY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External SR flop: captures the registered excitation each rising edge.
  always @(posedge clk) begin
    if (stuck_en) q_model <= stuck_val;
    else if (bus.s && !bus.r) q_model <= 1'b1;
    else if (bus.r && !bus.s) q_model <= 1'b0;
  end
  assign bus.q_fb = q_model;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] ref_exc(input logic q, input logic t);
    if (q == t) return EXC_HOLD;
    return t ? EXC_SET : EXC_RST;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (mon_en) begin
      check("sr_exclusive", bus.s & bus.r, 0);
      check("err_without_done", bus.err & ~bus.done, 0);
      if (bus.s) set_cycles++;
      if (bus.done) begin
        done_cnt++;
        check("done_expected", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          check("done_err", bus.err, e.err);
          check("done_lat", cyc - e.acc, e.lat);
        end
      end
    end
  end

  task automatic send(input logic b, input logic [1:0] exp_exc, input bit auto_exc,
                      input logic exp_err, input int exp_lat, input bit track,
                      input bit hold, output int acc);
    int   n = 0;
    logic [1:0] want;
    exp_t e;
    acc = -1;
    @(negedge clk);
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check("ready_timeout", bus.req_ready, 1);
      return;
    end
    bus.req_bit   = b;
    bus.req_valid = 1'b1;
    want = auto_exc ? ref_exc(q_model, b) : exp_exc;
    @(posedge clk);
    #1;
    acc = cyc;
    if (track) begin
      acc_cnt++;
      e.err = exp_err;
      e.lat = exp_lat;
      e.acc = acc;
      sb_q.push_back(e);
    end
    check("excitation", {bus.s, bus.r}, want);
    if (!hold) bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("drain", sb_q.size(), 0);
  endtask

  initial begin
    int acc, prev, sets0, gap;
    logic       b2b_bit[4];
    logic [1:0] b2b_exc[4];
    b2b_bit = '{1'b1, 1'b1, 1'b0, 1'b1};
    b2b_exc = '{EXC_SET, EXC_HOLD, EXC_RST, EXC_SET};
    prev = 0;

    reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_bit   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_s", bus.s, 0);
    check("rst_r", bus.r, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_cnt", bus.mismatch_cnt, 0);
    check("rst_ready", bus.req_ready, 1);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Q starts at 1; request 0 must pulse r once. req_bit changes after accept are ignored.
    send(1'b0, EXC_RST, 1'b0, 1'b0, 2, 1'b1, 1'b0, acc);
    bus.req_bit = 1'b1;
    check("t1_ready_busy", bus.req_ready, 0);
    @(posedge clk);
    #1;
    check("t1_sr_release", {bus.s, bus.r}, EXC_HOLD);
    drain();
    check("t1_q", q_model, 0);
    check("t1_cnt", bus.mismatch_cnt, 0);

    // Back-to-back with valid held high: one accept every three edges.
    for (int i = 0; i < 4; i++) begin
      send(b2b_bit[i], b2b_exc[i], 1'b0, 1'b0, 2, 1'b1, 1'b1, acc);
      if (i > 0) check("b2b_spacing", acc - prev, 3);
      prev = acc;
    end
    bus.req_valid = 1'b0;
    drain();
    check("b2b_q", q_model, 1);
    check("b2b_cnt", bus.mismatch_cnt, 0);

    // Flop stuck at 0, request 1.
    stuck_en = 1'b1;
    repeat (2) @(negedge clk);
    sets0 = set_cycles;
    send(1'b1, EXC_SET, 1'b0, 1'b1, LAT_STUCK, 1'b1, 1'b0, acc);
    drain();
    check("stuck_cnt", bus.mismatch_cnt, FAILS_PER_REQ);
    check("stuck_set_pulses", set_cycles - sets0, FAILS_PER_REQ);

    // Flop released right after the first attempt is captured.
    sets0 = set_cycles;
    send(1'b1, EXC_SET, 1'b0, ERR_FREED, LAT_FREED, 1'b1, 1'b0, acc);
    @(posedge clk);
    #1;
    stuck_en = 1'b0;
    drain();
    check("freed_cnt", bus.mismatch_cnt, FAILS_PER_REQ + 1);
    check("freed_set_pulses", set_cycles - sets0, SETS_FREED);

    // Saturate the mismatch counter.
    stuck_en = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 261 / FAILS_PER_REQ; i++) begin
      send(1'b1, EXC_SET, 1'b0, 1'b1, LAT_STUCK, 1'b1, 1'b0, acc);
    end
    drain();
    check("sat_cnt", bus.mismatch_cnt, 8'hFF);

    // Reset during DRIVE abandons the request.
    send(1'b1, EXC_SET, 1'b0, 1'b1, LAT_STUCK, 1'b0, 1'b0, acc);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_sr", {bus.s, bus.r}, EXC_HOLD);
    check("midrst_ready", bus.req_ready, 1);
    check("midrst_cnt", bus.mismatch_cnt, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      check("midrst_no_done", bus.done, 0);
    end

    // Random traffic on a healthy flop.
    stuck_en = 1'b0;
    for (int i = 0; i < 2400; i++) begin
      gap = $urandom_range(0, 4);
      send(1'($urandom_range(0, 1)), EXC_HOLD, 1'b1, 1'b0, 2, 1'b1, gap == 0, acc);
      repeat (gap) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    drain();
    check("rand_done_eq_accepts", done_cnt, acc_cnt);
    check("rand_cnt", bus.mismatch_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
